// File: rtl/or_input_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// or_input_pkg
// Shared types and default constants for the or_input_debouncer block.
//   debounce_state_t   : per-channel debounce FSM state
//   DEF_SYNC_STAGES    : default synchroniser depth
//   DEF_STABLE_CYCLES  : default number of stable samples before a change
//   level_of()         : debounced output level implied by an FSM state
// ---------------------------------------------------------------------------
package or_input_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    CHK_HIGH = 2'b01,
    HIGH     = 2'b10,
    CHK_LOW  = 2'b11
  } debounce_state_t;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 4;

  // The clean level is held while a reversal is being qualified, so both
  // HIGH and CHK_LOW present a 1 and both LOW and CHK_HIGH present a 0.
  function automatic logic level_of(input debounce_state_t s);
    return (s == HIGH) || (s == CHK_LOW);
  endfunction

endpackage

// File: rtl/or_input_debouncer_if.sv
// ---------------------------------------------------------------------------
// or_input_debouncer_if
// Bundles the raw inputs and the conditioned outputs of or_input_debouncer.
//   raw_in1, raw_in2 : raw asynchronous inputs
//   in1, in2         : debounced levels (feed or_gate.in1 / or_gate.in2)
//   edge1, edge2     : one-cycle change pulses
// Modports:
//   master : the side that produces raw inputs and consumes clean outputs
//   slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface or_input_debouncer_if;

  logic raw_in1;
  logic raw_in2;
  logic in1;
  logic in2;
  logic edge1;
  logic edge2;

  modport master (
    output raw_in1, raw_in2,
    input  in1, in2, edge1, edge2
  );

  modport slave (
    input  raw_in1, raw_in2,
    output in1, in2, edge1, edge2
  );

endinterface

// File: rtl/or_input_debouncer_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One-bit input conditioner: SYNC_STAGES-deep synchroniser followed by a
// four-state debounce FSM with a stability counter.
//   clk   : clock
//   rst   : asynchronous active-high reset (FSM held in LOW, all flops 0)
//   raw   : raw asynchronous input
//   out   : registered debounced level
//   pulse : registered one-cycle pulse in the first cycle out shows a change
// A change is accepted only after STABLE_CYCLES consecutive synchronised
// samples at the new level; shorter excursions return to the settled state.
// ---------------------------------------------------------------------------
module debounce_channel
  import or_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_channel: STABLE_CYCLES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_x;
  debounce_state_t        state;
  logic [CNT_W-1:0]       cnt;

  // Synchroniser: raw enters at bit 0, the FSM sees only the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_x = sync_q[SYNC_STAGES-1];

  // The transition into a CHK_* state already counts the first sample at
  // the new level, so the counter starts at 1 and completion happens on the
  // STABLE_CYCLES-th consecutive sample (cnt == STABLE_CYCLES-1 seen plus
  // the current one). cnt therefore never exceeds STABLE_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      out   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        LOW: begin
          if (sync_x) begin
            state <= CHK_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CHK_HIGH: begin
          if (!sync_x) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HIGH;
            cnt   <= '0;
            out   <= level_of(HIGH);
            pulse <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!sync_x) begin
            state <= CHK_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CHK_LOW: begin
          if (sync_x) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            cnt   <= '0;
            out   <= level_of(LOW);
            pulse <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
          out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/or_input_debouncer.sv
// ---------------------------------------------------------------------------
// or_input_debouncer
// Input-conditioning stage ahead of or_gate: synchronises and debounces two
// independent raw inputs and produces per-channel change pulses.
//   clk      : single clock for all state
//   rst      : asynchronous active-high reset
//   raw_in1  : raw asynchronous input, channel 1
//   raw_in2  : raw asynchronous input, channel 2
//   in1      : debounced level, channel 1 (to or_gate.in1)
//   in2      : debounced level, channel 2 (to or_gate.in2)
//   edge1    : one-cycle pulse when in1 changes
//   edge2    : one-cycle pulse when in2 changes
// The signal set matches or_input_debouncer_if (slave view) so an instance
// can be wired directly to members of that interface.
// ---------------------------------------------------------------------------
module or_input_debouncer
  import or_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in1,
  input  logic raw_in2,
  output logic in1,
  output logic in2,
  output logic edge1,
  output logic edge2
);

  debounce_channel #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_ch1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_in1),
    .out   (in1),
    .pulse (edge1)
  );

  debounce_channel #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_ch2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_in2),
    .out   (in2),
    .pulse (edge2)
  );

endmodule

// File: tb/tb_or_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_or_input_debouncer
// Bench for or_input_debouncer with a behavioural or_gate downstream.
// Tests push time-stamped expectations ({in1,in2}, {edge1,edge2}) into a
// scoreboard when they drive stimulus; a negedge monitor pops and compares
// them on the cycle they fall due. Tests also do their own inline checks.
// ---------------------------------------------------------------------------
module tb_or_input_debouncer;

  typedef struct {
    int unsigned at;
    logic [1:0]  lvl;
    logic [1:0]  edg;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        or_out;
  int unsigned cyc;
  int unsigned tests_run;
  int unsigned tests_failed;
  exp_t        sb[$];
  exp_t        mon_e;

  or_input_debouncer_if bus ();

  or_input_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .raw_in1 (bus.raw_in1),
    .raw_in2 (bus.raw_in2),
    .in1     (bus.in1),
    .in2     (bus.in2),
    .edge1   (bus.edge1),
    .edge2   (bus.edge2)
  );

  // downstream or_gate
  assign or_out = bus.in1 | bus.in2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void expect_at(input int unsigned at, input logic [1:0] lvl,
                                    input logic [1:0] edg, input string tag);
    exp_t e;
    e.at  = at;
    e.lvl = lvl;
    e.edg = edg;
    e.tag = tag;
    sb.push_back(e);
  endfunction

  // Scoreboard monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      tests_run++;
      if (mon_e.at != cyc) begin
        tests_failed++;
        $display("FAIL %s: sample cycle %0d missed, now %0d", mon_e.tag, mon_e.at, cyc);
      end else if ({bus.in1, bus.in2} !== mon_e.lvl ||
                   {bus.edge1, bus.edge2} !== mon_e.edg ||
                   or_out !== (mon_e.lvl[1] | mon_e.lvl[0])) begin
        tests_failed++;
        $display("FAIL %s @%0d: {in1,in2}=%b {edge1,edge2}=%b or=%b, required %b %b %b",
                 mon_e.tag, cyc, {bus.in1, bus.in2}, {bus.edge1, bus.edge2}, or_out,
                 mon_e.lvl, mon_e.edg, mon_e.lvl[1] | mon_e.lvl[0]);
      end
    end
  end

  task automatic step(input int unsigned k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
  endtask

  task automatic go_idle();
    bus.raw_in1 = 1'b0;
    bus.raw_in2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    bus.raw_in1 = 1'b0;
    bus.raw_in2 = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.in1, bus.in2, bus.edge1, bus.edge2} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_init: outputs=%b, required 0000",
               {bus.in1, bus.in2, bus.edge1, bus.edge2});
    end
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_async_reset();
    int unsigned n;
    int unsigned m;
    n = cyc;
    bus.raw_in1 = 1'b1;
    bus.raw_in2 = 1'b1;
    expect_at(n + 5, 2'b00, 2'b00, "arst_pre");
    expect_at(n + 6, 2'b11, 2'b11, "arst_rise");
    expect_at(n + 7, 2'b11, 2'b00, "arst_hold");
    step(16);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.in1, bus.in2, bus.edge1, bus.edge2} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL arst_immediate: outputs=%b, required 0000",
               {bus.in1, bus.in2, bus.edge1, bus.edge2});
    end
    step(2);
    m = cyc;
    rst = 1'b0;
    expect_at(m + 5, 2'b00, 2'b00, "arst_rel_pre");
    expect_at(m + 6, 2'b11, 2'b11, "arst_rel_rise");
    expect_at(m + 7, 2'b11, 2'b00, "arst_rel_hold");
    step(9);
    wait_drain();
  endtask

  task automatic test_single_rise();
    int unsigned n;
    logic bad;
    bad = 1'b0;
    n = cyc;
    bus.raw_in1 = 1'b1;
    expect_at(n + 5, 2'b00, 2'b00, "rise_pre");
    expect_at(n + 6, 2'b10, 2'b10, "rise_edge");
    expect_at(n + 7, 2'b10, 2'b00, "rise_hold");
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bus.in2 || bus.edge2) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL rise_ch2_quiet: ch2 activity=%b, required 0", bad);
    end
    wait_drain();
  endtask

  task automatic test_glitch();
    int unsigned p;
    logic bad;
    bad = 1'b0;
    bus.raw_in2 = 1'b1;
    step(3);
    bus.raw_in2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.in2 || bus.edge2) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch3_rejected: ch2 activity=%b, required 0", bad);
    end
    p = cyc;
    bus.raw_in2 = 1'b1;
    expect_at(p + 5, 2'b00, 2'b00, "pulse4_pre");
    expect_at(p + 6, 2'b01, 2'b01, "pulse4_rise");
    expect_at(p + 7, 2'b01, 2'b00, "pulse4_hold");
    expect_at(p + 9, 2'b01, 2'b00, "pulse4_prefall");
    expect_at(p + 10, 2'b00, 2'b01, "pulse4_fall");
    expect_at(p + 11, 2'b00, 2'b00, "pulse4_low");
    step(4);
    bus.raw_in2 = 1'b0;
    step(8);
    wait_drain();
  endtask

  task automatic test_fall_glitch();
    int unsigned n;
    int unsigned r;
    logic bad;
    bad = 1'b0;
    n = cyc;
    bus.raw_in1 = 1'b1;
    expect_at(n + 6, 2'b10, 2'b10, "fall_setup");
    step(9);
    bus.raw_in1 = 1'b0;
    step(2);
    bus.raw_in1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.in1 || bus.edge1) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL low_glitch_rejected: ch1 disturbed=%b, required 0", bad);
    end
    r = cyc;
    bus.raw_in1 = 1'b0;
    expect_at(r + 5, 2'b10, 2'b00, "fall_pre");
    expect_at(r + 6, 2'b00, 2'b10, "fall_edge");
    expect_at(r + 7, 2'b00, 2'b00, "fall_hold");
    step(9);
    wait_drain();
  endtask

  task automatic test_simultaneous();
    int unsigned n;
    n = cyc;
    bus.raw_in1 = 1'b1;
    bus.raw_in2 = 1'b1;
    expect_at(n + 5, 2'b00, 2'b00, "sim_00");
    expect_at(n + 6, 2'b11, 2'b11, "sim_rise_11");
    expect_at(n + 7, 2'b11, 2'b00, "sim_hold_11");
    step(9);
    n = cyc;
    bus.raw_in2 = 1'b0;
    expect_at(n + 5, 2'b11, 2'b00, "sim_pre_10");
    expect_at(n + 6, 2'b10, 2'b01, "sim_10");
    step(9);
    n = cyc;
    bus.raw_in1 = 1'b0;
    bus.raw_in2 = 1'b1;
    expect_at(n + 6, 2'b01, 2'b11, "sim_01");
    expect_at(n + 7, 2'b01, 2'b00, "sim_hold_01");
    step(9);
    wait_drain();
  endtask

  task automatic test_reset_during_count();
    int unsigned n;
    logic bad;
    bad = 1'b0;
    n = cyc;
    bus.raw_in1 = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_at(n + 10, 2'b00, 2'b00, "rdc_no_early");
    expect_at(n + 11, 2'b10, 2'b10, "rdc_rise");
    expect_at(n + 12, 2'b10, 2'b00, "rdc_hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.in1 || bus.edge1) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL rdc_early_assert: in1/edge1 seen=%b, required 0", bad);
    end
    step(4);
    wait_drain();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bus.raw_in1  = 1'b0;
    bus.raw_in2  = 1'b0;
    test_reset();
    test_async_reset();
    go_idle();
    test_single_rise();
    go_idle();
    test_glitch();
    go_idle();
    test_fall_glitch();
    go_idle();
    test_simultaneous();
    go_idle();
    test_reset_during_count();
    wait_drain();
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      tests_run++;
      tests_failed++;
      $display("FAIL %s: expectation for cycle %0d never checked, now %0d",
               mon_e.tag, mon_e.at, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/or_input_debouncer.md
Name: or_input_debouncer

Overview:
Input-conditioning stage directly upstream of or_gate. It takes two raw, asynchronous, possibly bouncing one-bit signals and synchronises each to clk. It debounces each one with a per-channel counter FSM and drives the clean levels straight onto or_gate's in1/in2. It also emits one-cycle change pulses per channel for downstream logging and counting.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per channel; must be >= 2 (elaboration-time check).
STABLE_CYCLES, 4, consecutive synchronised samples at the new level required before an output changes; must be >= 2 (elaboration-time check).
CNT_W, $clog2(STABLE_CYCLES), width of the per-channel stability counter; derived, not overridden.

Ports:
clk  input  1  single clock for all state
rst  input  1  asynchronous, active-high reset
raw_in1  input  1  raw asynchronous input, channel 1
raw_in2  input  1  raw asynchronous input, channel 2
in1  output  1  debounced level, channel 1; connects to or_gate.in1
in2  output  1  debounced level, channel 2; connects to or_gate.in2
edge1  output  1  one-cycle pulse when in1 changes (either direction)
edge2  output  1  one-cycle pulse when in2 changes (either direction)

Behaviour:
- One clock; reset is asynchronous and active-high on rst.
- While rst=1, all of the following are 0 immediately, not at the next clk edge:
  - synchroniser flops
  - counters
  - in1, in2, edge1, edge2
- While rst=1, both FSMs are held in LOW.
- All other state updates on posedge clk only.
- Channels are fully independent; no shared state except clk/rst.
- Synchroniser: a SYNC_STAGES-deep shift chain per channel. The FSM observes only the last stage (sync_x).
- Per-channel FSM states: LOW, CHK_HIGH, HIGH, CHK_LOW.
  - LOW: out=0. If sync_x=1, go to CHK_HIGH with cnt=1; else stay, cnt=0.
  - CHK_HIGH: out=0.
    - If sync_x=0: go to LOW, cnt=0 (glitch rejected, no pulse).
    - Else if cnt==STABLE_CYCLES-1: go to HIGH, out<=1, edge pulse.
    - Else cnt<=cnt+1.
  - HIGH: out=1. If sync_x=0, go to CHK_LOW with cnt=1; else stay, cnt=0.
  - CHK_LOW: mirror of CHK_HIGH with levels inverted. On completion go to LOW, out<=0, edge pulse.
- Outputs are registered; out is a function of state only.
- edgeX is registered high for exactly one cycle: the cycle in which inX first shows the new value.
- Latency: raw_inX is stable from just before edge k, where edge k is the first edge that samples it. inX changes at edge k+SYNC_STAGES+STABLE_CYCLES-1, which is k+5 with defaults.
- Any excursion shorter than STABLE_CYCLES synchronised samples is rejected. Output and edge pulse are unaffected.
- Counter never exceeds STABLE_CYCLES-1. No wrap-around is possible.
- Simultaneous changes on both channels produce simultaneous output changes and pulses in the same cycle.
- Reset mid-operation (during CHK_*) discards partial counts. After release, the full latency applies again from the first post-reset sampling edge.
- X on raw inputs is not propagated past reset. The bench drives known values.

Decomposition:
- Shared package or_input_pkg holds:
  - debounce_state_t enum {LOW, CHK_HIGH, HIGH, CHK_LOW}
  - default constants DEF_SYNC_STAGES=2, DEF_STABLE_CYCLES=4
- One sub-module, debounce_channel, containing synchroniser, FSM and counter for one bit, same parameters. It is instantiated twice in or_input_debouncer.
- The top level only wires the two instances. It does not contain or_gate; integration is done in the bench.

Test Plan:
1. Async reset: raw_in1=raw_in2=1 for 10 cycles with in1=in2=1 settled, then assert rst mid-cycle -> in1=in2=edge1=edge2=0 before the next clk edge. After release with raw still 1 -> in1=in2=1 again at release-edge+5.
2. Single rise: raw_in1 0->1 before edge k, held -> in1=1 from edge k+5, edge1=1 for exactly that one cycle, in2 and edge2 stay 0. Downstream or_gate.out=1 at the same time.
3. Glitch rejection: raw_in2 pulsed high for 3 cycles, then low -> in2 stays 0, edge2 never asserts. A pulse of 4 cycles -> in2 rises at k+5.
4. Fall and low glitch: in1=1 settled. A raw_in1 low pulse of 2 cycles -> in1 stays 1. Then raw_in1 low held -> in1=0 at k+5 with a one-cycle edge1.
5. Simultaneous: raw_in1 and raw_in2 rise in the same cycle -> in1, in2, edge1, edge2 all change on the same edge (k+5). Walk all four {in1,in2} combinations and check or_gate.out = 0, 1, 1, 1.
6. Reset during count: raw_in1 high for 2 synchronised samples (CHK_HIGH, cnt=2), pulse rst for 1 cycle, keep raw_in1 high -> in1 rises exactly 5 edges after the first post-reset sampling edge, with no early assertion.
